// File: rtl/stoch_window_sequencer.sv
// Sequencer for one stochastic multiply: seeds the SNG datapath, skips pipeline fill, counts ones over a 2^win window.
// Optional signed bipolar result is built only when STOCH_BIPOLAR_EN is defined.
module stoch_window_sequencer #(
  parameter int OPW      = 4,
  parameter int MAX_LOG2 = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OPW-1:0]        req_a,
  input  logic [OPW-1:0]        req_b,
  input  logic [3:0]            req_win,
  input  logic                  abort,
  output logic                  dp_seed_load,
  output logic                  dp_en,
  output logic [OPW-1:0]        dp_a,
  output logic [OPW-1:0]        dp_b,
  input  logic                  dp_sn_bit,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [MAX_LOG2:0]     res_ones,
  output logic [MAX_LOG2:0]     res_len,
  output logic [MAX_LOG2+1:0]   res_bipolar
);
  localparam int CW = MAX_LOG2 + 1;
  localparam int BW = MAX_LOG2 + 2;
  localparam logic [3:0] WMAX = 4'(MAX_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_FILL, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q, ones_q, len_q, res_ones_q, res_len_q;
  logic [OPW-1:0]  a_q, b_q;
  logic            req_ready_q, busy_q, seed_q, en_q, res_valid_q;
  logic [3:0]      win_c;
  logic [CW-1:0]   len_d, ones_d;
  logic            kill;

  assign win_c  = (req_win > WMAX) ? WMAX : req_win;
  assign len_d  = CW'(1) << win_c;
  assign ones_d = ones_q + CW'(dp_sn_bit);
  // Abort only matters once an operation is in flight; in IDLE it must not block an accept.
  assign kill   = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ones_q      <= '0;
      len_q       <= '0;
      res_ones_q  <= '0;
      res_len_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      seed_q      <= 1'b0;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      seed_q <= 1'b0;
      if (kill) begin
        state_q     <= S_IDLE;
        ones_q      <= '0;
        res_ones_q  <= '0;
        res_len_q   <= '0;
        req_ready_q <= 1'b1;
        busy_q      <= 1'b0;
        en_q        <= 1'b0;
        res_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (req_valid) begin
            state_q     <= S_SEED;
            a_q         <= req_a;
            b_q         <= req_b;
            len_q       <= len_d;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            seed_q      <= 1'b1;
          end
          S_SEED: begin
            en_q <= 1'b1;
            if (PIPE_LAT == 0) begin
              state_q <= S_RUN;
              cnt_q   <= len_q - CW'(1);
              ones_q  <= '0;
            end else begin
              state_q <= S_FILL;
              cnt_q   <= CW'(PIPE_LAT - 1);
            end
          end
          S_FILL: begin
            if (cnt_q == '0) begin
              state_q <= S_RUN;
              cnt_q   <= len_q - CW'(1);
              ones_q  <= '0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_RUN: begin
            ones_q <= ones_d;
            if (cnt_q == '0) begin
              state_q     <= S_DONE;
              en_q        <= 1'b0;
              res_valid_q <= 1'b1;
              res_ones_q  <= ones_d;
              res_len_q   <= len_q;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_DONE: if (res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef STOCH_BIPOLAR_EN
  logic [BW-1:0] bip_q;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                                bip_q <= '0;
    else if (kill)                            bip_q <= '0;
    else if (state_q == S_RUN && cnt_q == '0) bip_q <= {ones_d, 1'b0} - {1'b0, len_q};
  end
  assign res_bipolar = bip_q;
`else
  assign res_bipolar = '0;
`endif

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign dp_seed_load = seed_q;
  assign dp_en        = en_q;
  assign dp_a         = a_q;
  assign dp_b         = b_q;
  assign res_valid    = res_valid_q;
  assign res_ones     = res_ones_q;
  assign res_len      = res_len_q;
endmodule

// File: tb/tb_stoch_window_sequencer.sv
// Randomized bench for stoch_window_sequencer: drives a bitstream per cycle and predicts the
// result from the cycle schedule (seed, PIPE_LAT fill cycles, N counted cycles).
module tb_stoch_window_sequencer;
  localparam int OPW = 4;
  localparam int ML  = 8;
  localparam int P   = 2;
  localparam int CW  = ML + 1;
  localparam int BW  = ML + 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, abort, dp_seed_load, dp_en, dp_sn_bit;
  logic           busy, res_valid, res_ready;
  logic [OPW-1:0] req_a, req_b, dp_a, dp_b;
  logic [3:0]     req_win;
  logic [CW-1:0]  res_ones, res_len;
  logic [BW-1:0]  res_bipolar;

  int checks = 0;
  int passes = 0;
  bit stream [0:299];

  stoch_window_sequencer #(.OPW(OPW), .MAX_LOG2(ML), .PIPE_LAT(P)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_win(req_win), .abort(abort),
    .dp_seed_load(dp_seed_load), .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b),
    .dp_sn_bit(dp_sn_bit), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_ones(res_ones), .res_len(res_len), .res_bipolar(res_bipolar)
  );

  always #5 clk = ~clk;

  // Idle-state outputs as seen in IDLE after reset
  task automatic check_idle(input string nm);
    checks++;
    if ({req_ready, busy, dp_seed_load, dp_en, res_valid} !== 5'b10000)
      $display("FAIL %s: rdy/busy/seed/en/rv got %b expected 10000", nm,
               {req_ready, busy, dp_seed_load, dp_en, res_valid});
    else passes++;
  endtask

  // One full operation. Index 0 is the cycle after the accept edge (seed),
  // 1..P are fill cycles, P+1..P+N are counted, P+N+1 shows the result.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] win,
                        input int mode, input int hold, input bit abort_acc);
    int w, n, exp_ones;
    logic [BW-1:0] exp_bip;
    w = (int'(win) > ML) ? ML : int'(win);
    n = 1 << w;
    for (int i = 0; i <= P + n; i++) begin
      case (mode)
        1:       stream[i] = 1'b1;
        2:       stream[i] = (i <= P);
        3:       stream[i] = (i > P) ? (((i - P - 1) % 2) == 0) : 1'b1;
        default: stream[i] = 1'($urandom_range(0, 1));
      endcase
    end
    exp_ones = 0;
    for (int i = P + 1; i <= P + n; i++) exp_ones += int'(stream[i]);
`ifdef STOCH_BIPOLAR_EN
    exp_bip = BW'(2 * exp_ones - n);
`else
    exp_bip = '0;
`endif
    checks++;
    if (req_ready !== 1'b1) $display("FAIL pre_accept_ready: got %b expected 1", req_ready);
    else passes++;
    req_valid = 1'b1; req_a = a; req_b = b; req_win = win; abort = abort_acc; dp_sn_bit = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    req_a = 4'($urandom); req_b = 4'($urandom);
    checks++;
    if ({dp_seed_load, dp_en, busy, req_ready} !== 4'b1010)
      $display("FAIL seed_cycle: seed/en/busy/rdy got %b expected 1010",
               {dp_seed_load, dp_en, busy, req_ready});
    else passes++;
    dp_sn_bit = stream[0];
    for (int i = 1; i <= P + n; i++) begin
      @(negedge clk);
      checks++;
      if (dp_en !== 1'b1 || dp_seed_load !== 1'b0 || res_valid !== 1'b0 || dp_a !== a || dp_b !== b)
        $display("FAIL active_cycle%0d: en=%b seed=%b rv=%b a=%0d b=%0d expected en=1 seed=0 rv=0 a=%0d b=%0d",
                 i, dp_en, dp_seed_load, res_valid, dp_a, dp_b, a, b);
      else passes++;
      dp_sn_bit = stream[i];
      req_win = 4'($urandom);
    end
    @(negedge clk);
    dp_sn_bit = 1'($urandom);
    checks++;
    if (res_valid !== 1'b1 || dp_en !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL done_latency: rv=%b en=%b rdy=%b expected 1 0 0", res_valid, dp_en, req_ready);
    else passes++;
    checks++;
    if (res_ones !== CW'(exp_ones)) $display("FAIL res_ones: got %0d expected %0d", res_ones, exp_ones);
    else passes++;
    checks++;
    if (res_len !== CW'(n)) $display("FAIL res_len: got %0d expected %0d", res_len, n);
    else passes++;
    checks++;
    if (res_bipolar !== exp_bip) $display("FAIL res_bipolar: got %0d expected %0d",
                                          $signed(res_bipolar), $signed(exp_bip));
    else passes++;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_ones !== CW'(exp_ones) || res_bipolar !== exp_bip)
        $display("FAIL done_hold%0d: rv=%b rdy=%b ones=%0d expected 1 0 %0d", k, res_valid, req_ready,
                 res_ones, exp_ones);
      else passes++;
    end
    // Offer a request during the handshake cycle: it must not be taken
    res_ready = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; req_valid = 1'b0;
    check_idle("after_handshake");
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_win = '0;
    abort = 1'b0; dp_sn_bit = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_ctrl");
    checks++;
    if ({dp_a, dp_b, res_ones, res_len, res_bipolar} !== '0)
      $display("FAIL reset_data: got %h expected 0", {dp_a, dp_b, res_ones, res_len, res_bipolar});
    else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_all_ones();  run_op(4'd15, 4'd15, 4'd3, 1, 0, 1'b0); endtask
  task automatic test_fill_ignored(); run_op(4'd7, 4'd9, 4'd4, 2, 0, 1'b0); endtask
  task automatic test_toggle();    run_op(4'd5, 4'd10, 4'd5, 3, 0, 1'b0); endtask
  task automatic test_clamp();     run_op(4'd3, 4'd12, 4'd12, 0, 0, 1'b0); endtask
  task automatic test_win0();      run_op(4'd1, 4'd2, 4'd0, 1, 0, 1'b0); endtask
  task automatic test_hold();      run_op(4'd8, 4'd8, 4'd2, 0, 10, 1'b0); endtask
  task automatic test_abort_idle(); run_op(4'd6, 4'd11, 4'd3, 0, 1, 1'b1); endtask

  task automatic test_abort();
    req_valid = 1'b1; req_a = 4'd4; req_b = 4'd13; req_win = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (P + 3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_run");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_quiet%0d: rv=%b busy=%b expected 0 0", k, res_valid, busy);
      else passes++;
    end
    run_op(4'd2, 4'd14, 4'd3, 0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1; req_a = 4'd9; req_b = 4'd9; req_win = 4'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_idle("async_reset");
    checks++;
    if ({dp_a, dp_b, res_ones, res_len} !== '0)
      $display("FAIL async_reset_data: got %h expected 0", {dp_a, dp_b, res_ones, res_len});
    else passes++;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle("after_async_reset");
    run_op(4'd9, 4'd3, 4'd4, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++)
      run_op(4'($urandom), 4'($urandom), 4'($urandom_range(0, 10)), 0, $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_fill_ignored();
    test_toggle();
    test_clamp();
    test_win0();
    test_hold();
    test_abort_idle();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
